// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 16-bit CPU core: instruction ROM, PC, IR,
// FETCH/DECODE/EXECUTE/WRITEBACK stepping and datapath control decode.
module control_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        zero_flag,
    input  logic        pos_flag,
    output logic        rf_write,
    output logic [2:0]  rs_addr,
    output logic [2:0]  rt_addr,
    output logic [2:0]  rd_addr,
    output logic [15:0] imm_data,
    output logic [3:0]  alu_sel,
    output logic        imm_sel,
    output logic        mem_write,
    output logic        mem_sel,
    output logic [4:0]  PC
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned PC_W   = 5;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned OP_W   = 4;

    localparam logic [2:0] S_INIT      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h9;
    localparam logic [OP_W-1:0] OP_MOVI = 4'hB;
    localparam logic [OP_W-1:0] OP_LD   = 4'hC;
    localparam logic [OP_W-1:0] OP_ST   = 4'hD;
    localparam logic [OP_W-1:0] OP_BR   = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    logic [2:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              rf_write_q, rf_write_d;
    logic              mem_write_q, mem_write_d;

    logic [DATA_W-1:0] rom_word;
    logic [OP_W-1:0]   opcode;
    logic [PC_W-1:0]   pc_inc;
    logic              writes_rf;
    logic              br_taken;

    assign opcode    = ir_q[15:12];
    assign pc_inc    = pc_q + PC_W'(1);
    assign writes_rf = (opcode >= 4'h1) && (opcode <= OP_LD);

    // Program ROM; unlisted words read as NOP.
    always_comb begin
        rom_word = '0;
        case (pc_q)
            5'd2:    rom_word = 16'hB605;
            5'd3:    rom_word = 16'hB201;
            5'd4:    rom_word = 16'h26C8;
            5'd5:    rom_word = 16'hE407;
            5'd6:    rom_word = 16'hE004;
            5'd7:    rom_word = 16'hF000;
            default: rom_word = '0;
        endcase
    end

    assign rd_addr = ir_q[11:9];
    assign rs_addr = ir_q[8:6];
    assign rt_addr = ir_q[5:3];

    // Datapath steering decoded straight from IR, valid in every state.
    always_comb begin
        imm_data = '0;
        alu_sel  = '0;
        imm_sel  = 1'b0;
        mem_sel  = 1'b0;
        case (opcode)
            OP_ADDI: begin
                alu_sel  = opcode;
                imm_sel  = 1'b1;
                imm_data = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
            end
            OP_MOVI: begin
                alu_sel  = opcode;
                imm_sel  = 1'b1;
                imm_data = {{(DATA_W-9){ir_q[8]}}, ir_q[8:0]};
            end
            OP_LD:   mem_sel = 1'b1;
            OP_NOP, OP_ST, OP_BR, OP_HALT: ;
            default: alu_sel = opcode;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (ir_q[11:10])
            2'b00:   br_taken = 1'b1;
            2'b01:   br_taken = zero_flag;
            2'b10:   br_taken = pos_flag;
            default: br_taken = !zero_flag && !pos_flag;
        endcase
    end

    // Write strobes are registered on entry to WRITEBACK so they cover exactly that cycle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        rf_write_d  = 1'b0;
        mem_write_d = 1'b0;
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = rom_word;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP: begin
                        state_d = S_FETCH;
                        pc_d    = pc_inc;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                if (opcode == OP_BR) begin
                    state_d = S_FETCH;
                    pc_d    = br_taken ? ir_q[PC_W-1:0] : pc_inc;
                end else begin
                    state_d     = S_WRITEBACK;
                    rf_write_d  = writes_rf;
                    mem_write_d = (opcode == OP_ST);
                end
            end
            S_WRITEBACK: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_INIT;
            pc_q        <= '0;
            ir_q        <= '0;
            rf_write_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            rf_write_q  <= rf_write_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign rf_write  = rf_write_q;
    assign mem_write = mem_write_q;
    assign PC        = pc_q;

    // Register-address width is fixed by the instruction format.
    if (REG_W != 3) begin : g_bad_reg_w
        $error("REG_W must be 3");
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: runs the ROM program through reset,
// the countdown loop, a taken JZ into HALT, and a reset during WRITEBACK.
module tb_control_unit;

    logic        clock;
    logic        reset;
    logic        zero_flag;
    logic        pos_flag;
    logic        rf_write;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic [2:0]  rd_addr;
    logic [15:0] imm_data;
    logic [3:0]  alu_sel;
    logic        imm_sel;
    logic        mem_write;
    logic        mem_sel;
    logic [4:0]  PC;

    int vectors     = 0;
    int miscompares = 0;
    int rf_cnt      = 0;
    int mw_cnt      = 0;

    control_unit dut (
        .clock     (clock),
        .reset     (reset),
        .zero_flag (zero_flag),
        .pos_flag  (pos_flag),
        .rf_write  (rf_write),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rd_addr   (rd_addr),
        .imm_data  (imm_data),
        .alu_sel   (alu_sel),
        .imm_sel   (imm_sel),
        .mem_write (mem_write),
        .mem_sel   (mem_sel),
        .PC        (PC)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if (rf_write === 1'b1)  rf_cnt = rf_cnt + 1;
            if (mem_write !== 1'b0) mw_cnt = mw_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors = vectors + 1;
        assert (obs === exp)
        else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    initial begin
        int base;
        reset     = 1'b1;
        zero_flag = 1'b0;
        pos_flag  = 1'b0;

        tick(1);
        check("rst_pc", 16'(PC), 16'h0000);
        check("rst_rf_write", 16'(rf_write), 16'h0000);
        check("rst_mem_write", 16'(mem_write), 16'h0000);
        check("rst_alu_sel", 16'(alu_sel), 16'h0000);
        reset = 1'b0;

        // INIT, NOP, NOP -> FETCH of PC 2 on the 5th edge
        tick(5);
        check("fetch2_pc", 16'(PC), 16'h0002);
        check("fetch2_rf_write", 16'(rf_write), 16'h0000);
        tick(1);
        check("movi3_rd", 16'(rd_addr), 16'h0003);
        check("movi3_alu_sel", 16'(alu_sel), 16'h000B);
        check("movi3_imm_sel", 16'(imm_sel), 16'h0001);
        check("movi3_imm_data", imm_data, 16'h0005);
        check("movi3_mem_sel", 16'(mem_sel), 16'h0000);
        check("movi3_dec_rf_write", 16'(rf_write), 16'h0000);
        tick(1);
        check("movi3_exe_rf_write", 16'(rf_write), 16'h0000);
        tick(1);
        check("movi3_wb_rf_write", 16'(rf_write), 16'h0001);
        tick(1);
        check("fetch3_rf_write", 16'(rf_write), 16'h0000);
        check("fetch3_pc", 16'(PC), 16'h0003);

        tick(1);
        check("movi1_rd", 16'(rd_addr), 16'h0001);
        check("movi1_imm_data", imm_data, 16'h0001);
        tick(2);
        check("movi1_wb_rf_write", 16'(rf_write), 16'h0001);
        tick(1);
        check("fetch4_pc", 16'(PC), 16'h0004);

        // SUB R3,R3,R1 decode fields
        tick(1);
        check("sub_rs", 16'(rs_addr), 16'h0003);
        check("sub_rt", 16'(rt_addr), 16'h0001);
        check("sub_rd", 16'(rd_addr), 16'h0003);
        check("sub_alu_sel", 16'(alu_sel), 16'h0002);
        check("sub_imm_sel", 16'(imm_sel), 16'h0000);
        check("sub_imm_data", imm_data, 16'h0000);
        tick(3);
        check("fetch5_pc", 16'(PC), 16'h0005);
        tick(1);
        check("jz_alu_sel", 16'(alu_sel), 16'h0000);
        check("jz_imm_data", imm_data, 16'h0000);
        tick(1);
        check("jz_exe_rf_write", 16'(rf_write), 16'h0000);
        tick(1);
        check("jz_not_taken_pc", 16'(PC), 16'h0006);
        tick(3);
        check("jmp_pc", 16'(PC), 16'h0004);

        // One more loop pass: exactly one RF write; pos_flag must not take JZ
        base = rf_cnt;
        tick(6);
        pos_flag = 1'b1;
        tick(1);
        pos_flag = 1'b0;
        check("jz_pos_not_taken_pc", 16'(PC), 16'h0006);
        tick(3);
        check("loop2_pc", 16'(PC), 16'h0004);
        check("loop2_rf_pulses", 16'(rf_cnt - base), 16'h0001);

        // Taken JZ into HALT
        tick(6);
        zero_flag = 1'b1;
        tick(1);
        zero_flag = 1'b0;
        check("jz_taken_pc", 16'(PC), 16'h0007);
        tick(1);
        check("halt_alu_sel", 16'(alu_sel), 16'h0000);
        base = rf_cnt;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("halt_pc", 16'(PC), 16'h0007);
            check("halt_rf_write", 16'(rf_write), 16'h0000);
            check("halt_mem_write", 16'(mem_write), 16'h0000);
        end
        check("halt_rf_pulses", 16'(rf_cnt - base), 16'h0000);

        // Reset during MOVI WRITEBACK, then identical restart timing
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(5);
        check("r1_fetch2_pc", 16'(PC), 16'h0002);
        tick(3);
        check("r1_wb_rf_write", 16'(rf_write), 16'h0001);
        reset = 1'b1;
        tick(1);
        check("midrst_rf_write", 16'(rf_write), 16'h0000);
        check("midrst_pc", 16'(PC), 16'h0000);
        check("midrst_alu_sel", 16'(alu_sel), 16'h0000);
        reset = 1'b0;
        tick(1);
        check("midrst_init_pc", 16'(PC), 16'h0000);
        check("midrst_init_rf_write", 16'(rf_write), 16'h0000);
        tick(4);
        check("r2_fetch2_pc", 16'(PC), 16'h0002);
        check("r2_fetch2_rf_write", 16'(rf_write), 16'h0000);
        tick(1);
        check("r2_movi3_alu_sel", 16'(alu_sel), 16'h000B);
        check("r2_movi3_imm_data", imm_data, 16'h0005);
        tick(1);
        check("r2_exe_rf_write", 16'(rf_write), 16'h0000);
        tick(1);
        check("r2_wb_rf_write", 16'(rf_write), 16'h0001);
        tick(1);
        check("r2_fetch3_rf_write", 16'(rf_write), 16'h0000);
        check("r2_fetch3_pc", 16'(PC), 16'h0003);

        check("mem_write_never", 16'(mw_cnt), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
